// File: rtl/gate_bit_arb_if.sv
// Request/result bundle between client control FSMs and the shared gate arbiter.
interface gate_bit_arb_if #(
   parameter int C_REQUESTERS = 4,
   parameter int C_INPUTS     = 8
);
   localparam int W = (C_REQUESTERS > 1) ? $clog2(C_REQUESTERS) : 1;

   logic                             CE;
   logic                             FLUSH;
   logic [C_REQUESTERS-1:0]          REQ;
   logic [C_REQUESTERS*C_INPUTS-1:0] REQ_DATA;
   logic [C_REQUESTERS*C_INPUTS-1:0] REQ_INV;
   logic [C_REQUESTERS*3-1:0]        REQ_TYPE;
   logic [C_REQUESTERS-1:0]          GNT;
   logic                             RES_VALID;
   logic                             RES_BIT;
   logic [W-1:0]                     RES_ID;
   logic                             RES_ERR;
   logic                             BUSY;

   modport master (
      output CE, FLUSH, REQ, REQ_DATA, REQ_INV, REQ_TYPE,
      input  GNT, RES_VALID, RES_BIT, RES_ID, RES_ERR, BUSY
   );

   modport slave (
      input  CE, FLUSH, REQ, REQ_DATA, REQ_INV, REQ_TYPE,
      output GNT, RES_VALID, RES_BIT, RES_ID, RES_ERR, BUSY
   );
endinterface

// File: rtl/gate_bit_arb.sv
// Round-robin arbiter feeding one shared, pipelined reduction-gate unit;
// results come back tagged with the requester index.
module gate_bit_arb #(
   parameter int C_REQUESTERS  = 4,
   parameter int C_INPUTS      = 8,
   parameter int C_PIPE_STAGES = 2
) (
   input  logic          CLK,
   input  logic          ACLR_N,
   gate_bit_arb_if.slave bus
);
   localparam int N = C_REQUESTERS;
   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam int P = C_PIPE_STAGES;

   logic [W-1:0]          ptr_q;
   logic [W-1:0]          ptr_nxt;
   logic [W-1:0]          gnt_sel;
   logic                  found;
   logic [N-1:0]          gnt;
   logic                  accept;
   logic [C_INPUTS-1:0]   sel_data;
   logic [C_INPUTS-1:0]   sel_inv;
   logic [C_INPUTS-1:0]   operand;
   logic [2:0]            sel_type;
   logic                  eval_bit;
   logic                  eval_err;

   logic [P:0]            vld_q;
   logic [P:0]            bit_q;
   logic [P:0]            err_q;
   logic [W-1:0]          id_q [0:P];

   // Scan from ptr_q upward with wrap; first asserted request wins.
   always_comb begin
      found   = 1'b0;
      gnt_sel = '0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && bus.REQ[i] && (i == (int'(ptr_q) + k) % N)) begin
               found   = 1'b1;
               gnt_sel = W'(i);
            end
         end
      end
      gnt = '0;
      for (int i = 0; i < N; i++) begin
         gnt[i] = found && ACLR_N && bus.CE && !bus.FLUSH && (gnt_sel == W'(i));
      end
   end

   assign accept  = |(bus.REQ & gnt);
   assign ptr_nxt = (gnt_sel == W'(N - 1)) ? '0 : gnt_sel + 1'b1;

   always_comb begin
      sel_data = '0;
      sel_inv  = '0;
      sel_type = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_sel == W'(i)) begin
            sel_data = bus.REQ_DATA[i*C_INPUTS +: C_INPUTS];
            sel_inv  = bus.REQ_INV[i*C_INPUTS +: C_INPUTS];
            sel_type = bus.REQ_TYPE[i*3 +: 3];
         end
      end
   end

   // Plain reduction operators keep 4-state X masking: a dominant bit hides X.
   assign operand = sel_data ^ sel_inv;

   always_comb begin
      eval_bit = 1'b0;
      eval_err = 1'b0;
      case (sel_type)
         3'd0:    eval_bit = &operand;
         3'd1:    eval_bit = ~&operand;
         3'd2:    eval_bit = |operand;
         3'd3:    eval_bit = ~|operand;
         3'd4:    eval_bit = ^operand;
         3'd5:    eval_bit = ~^operand;
         default: eval_err = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge ACLR_N) begin
      if (!ACLR_N) begin
         ptr_q <= '0;
         vld_q <= '0;
         bit_q <= '0;
         err_q <= '0;
         for (int s = 0; s <= P; s++) id_q[s] <= '0;
      end else if (bus.FLUSH) begin
         // Data/ID stages are left stale on purpose; only valid bits matter.
         vld_q <= '0;
         ptr_q <= '0;
      end else if (bus.CE) begin
         vld_q[0] <= accept;
         if (accept) begin
            bit_q[0] <= eval_bit;
            err_q[0] <= eval_err;
            id_q[0]  <= gnt_sel;
            ptr_q    <= ptr_nxt;
         end
         for (int s = 1; s <= P; s++) begin
            vld_q[s] <= vld_q[s-1];
            bit_q[s] <= bit_q[s-1];
            err_q[s] <= err_q[s-1];
            id_q[s]  <= id_q[s-1];
         end
      end
   end

   assign bus.GNT       = gnt;
   assign bus.RES_VALID = vld_q[P];
   assign bus.RES_BIT   = bit_q[P];
   assign bus.RES_ERR   = err_q[P];
   assign bus.RES_ID    = id_q[P];
   assign bus.BUSY      = |vld_q;
endmodule

// File: doc/gate_bit_arb.md
Name: gate_bit_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined, configurable reduction-gate unit (AND/NAND/OR/NOR/XOR/XNOR over C_INPUTS bits) among C_REQUESTERS clients.
- Accepts at most one request per cycle, tags it with the requester ID, and drives the vector through a C_PIPE_STAGES-deep datapath.
- Returns the 1-bit result with its ID.
- Sits between client control FSMs and the shared gate resource. It replaces per-client gate instances where area matters.

Parameters:
- C_REQUESTERS, 4, number of clients (2..16); ID width W = clog2(C_REQUESTERS).
- C_INPUTS, 8, gate operand width per request (1..32).
- C_PIPE_STAGES, 2, extra register stages after the gate-evaluation register (0..8).

Ports:
- CLK  in  1  clock, rising edge.
- ACLR_N  in  1  asynchronous reset, active low.
- CE  in  1  clock enable; 0 freezes arbitration and pipeline.
- FLUSH  in  1  synchronous flush of in-flight work; has priority over CE.
- REQ  in  C_REQUESTERS  per-client request, held until granted.
- REQ_DATA  in  C_REQUESTERS*C_INPUTS  operand vectors; client i uses slice [i*C_INPUTS +: C_INPUTS].
- REQ_INV  in  C_REQUESTERS*C_INPUTS  per-bit input inversion masks, same slicing.
- REQ_TYPE  in  C_REQUESTERS*3  gate type per client: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
- GNT  out  C_REQUESTERS  one-hot combinational grant; request i is accepted on an edge where REQ[i]&GNT[i].
- RES_VALID  out  1  result valid, one-cycle pulse per accepted request.
- RES_BIT  out  1  gate result.
- RES_ID  out  W  requester index of the result.
- RES_ERR  out  1  with RES_VALID: request carried illegal type 6/7.
- BUSY  out  1  OR of all pipeline valid bits.

Behaviour:
- Reset (ACLR_N=0, asynchronous):
  - all pipeline valid/data/ID/err regs = 0; RES_VALID=0, RES_BIT=0, RES_ID=0, RES_ERR=0, BUSY=0.
  - round-robin pointer PTR=0.
  - GNT=0 while ACLR_N=0.
  - Deassertion is sampled synchronously; the first grant is possible in the first cycle with ACLR_N=1.
- Arbitration (combinational):
  - When CE=1 and FLUSH=0, GNT selects the first asserted REQ scanning PTR, PTR+1, ..., wrapping modulo C_REQUESTERS.
  - GNT=0 if no REQ is asserted, or if CE=0 or FLUSH=1.
- Pointer:
  - On an accept edge, PTR <= granted index + 1, wrapping to 0 after C_REQUESTERS-1.
  - Otherwise PTR holds.
- Gate evaluation:
  - Operand bit j = REQ_DATA bit j XOR REQ_INV bit j.
  - AND/NAND fold from 1; OR/NOR/XOR/XNOR fold from 0; NAND/NOR/XNOR invert the final value.
  - An operand bit that is X/Z yields X only when it can affect the result (AND with partial result 1, OR with partial result 0, XOR/XNOR always).
  - Type 6/7: result 0 and error flag 1.
- Pipeline:
  - Stage 0 registers {valid, result, ID, err} on the accept edge.
  - C_PIPE_STAGES further stages follow; the last stage drives the RES_* outputs directly.
  - Latency: a request accepted on edge k appears on RES_* after edge k+C_PIPE_STAGES. C_PIPE_STAGES=0 means the result is visible the cycle after acceptance.
  - Full throughput: one result per cycle while CE=1.
  - RES_VALID is asserted for exactly one enabled cycle per accepted request.
- CE=0:
  - all registers and PTR hold; RES_VALID/RES_* hold their current values.
  - A result pulse is therefore extended until the next CE=1 edge. Consumers qualify with CE.
- FLUSH=1 at an edge:
  - all valid bits cleared and PTR <= 0, regardless of CE.
  - No accept occurs that cycle; data/ID regs may hold stale values.
  - RES_VALID=0 and BUSY=0 after the edge.
- Simultaneous events:
  - A new accept and an exiting result in the same edge are both handled; there is no structural hazard.
  - REQ deasserted in the same cycle GNT would have asserted means no accept, and PTR holds.
- Requesters are not required to hold REQ_DATA stable after acceptance. Operands are captured at the accept edge.

Test Plan:
- Reset then single request:
  - Stimulus: C_PIPE_STAGES=2; REQ=0001, REQ_TYPE[0]=0 (AND), REQ_DATA[0]=8'hFF, REQ_INV=0.
  - Required: GNT=0001 in the same cycle; RES_VALID=1, RES_BIT=1, RES_ID=0 exactly 2 edges after accept; BUSY=0 afterwards.
- Round-robin fairness:
  - Stimulus: REQ=1111 held for 8 cycles.
  - Required: grants in order 0,1,2,3,0,1,2,3; RES_ID follows the same order with 2-cycle lag; RES_VALID continuous for 8 cycles.
- Inversion and types:
  - Client 2, data 8'h0F, inv 8'hF0, type 1 (NAND) -> RES_BIT=0.
  - Client 2, data 8'h0F, inv 0, type 4 (XOR) -> 0.
  - Client 2, data 8'h01, type 5 (XNOR) -> 0.
  - Client 2, type 7 -> RES_ERR=1, RES_BIT=0.
- CE stall mid-flight:
  - Stimulus: accept a request, then drop CE for 3 cycles.
  - Required: GNT=0 during the stall, PTR frozen, result appears 3 cycles later than nominal with correct RES_BIT/RES_ID; exactly one RES_VALID with CE=1.
- FLUSH with 3 in flight:
  - Stimulus: FLUSH pulses for one cycle while CE=0.
  - Required: no RES_VALID ever for those requests; BUSY=0; next grant goes to the lowest asserted index (PTR=0).
- Async reset mid-operation:
  - Stimulus: drop ACLR_N between edges with pipeline full.
  - Required: RES_VALID, BUSY, GNT go to 0 immediately, without waiting for a clock; after release, REQ=1000 is granted and returns RES_ID=3.
